// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ write-domain requesters.
// A grant streams up to MAX_BURST beats and never writes while the FIFO is full.
module fifo_wr_arbiter #(
   parameter int WIDTH     = 8,
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                       wr_clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]         ack,
   output logic [NUM_REQ-1:0]         gnt,
   input  logic                       fifo_full,
   output logic                       fifo_wr_en,
   output logic [WIDTH-1:0]           fifo_wr_data,
   output logic                       busy
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state;
   logic [IW-1:0]   g_idx;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   pick_idx;
   logic [IW-1:0]   scan_idx;
   logic [IW-1:0]   next_ptr;
   logic            pick_found;
   logic [CW-1:0]   beat_cnt;
   logic            accept;
   logic            last_beat;

   // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      scan_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = IW'((int'(rr_ptr) + i) % NUM_REQ);
         if (!pick_found && req[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

   assign accept    = (state == BUSY) & req[g_idx] & ~fifo_full & ~rst;
   assign last_beat = (beat_cnt == CW'(MAX_BURST - 1));
   assign next_ptr  = (g_idx == IW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;

   assign fifo_wr_en   = accept;
   assign ack          = accept ? gnt : '0;
   assign fifo_wr_data = (|gnt) ? req_data[g_idx*WIDTH +: WIDTH] : '0;
   assign busy         = (state == BUSY);

   always_ff @(posedge wr_clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= '0;
         g_idx    <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  state    <= BUSY;
                  gnt      <= NUM_REQ'(1) << pick_idx;
                  g_idx    <= pick_idx;
                  beat_cnt <= '0;
               end
            end
            BUSY: begin
               // A dropped request ends the grant just like a completed burst.
               if (!req[g_idx] || (accept && last_beat)) begin
                  state    <= IDLE;
                  gnt      <= '0;
                  beat_cnt <= '0;
                  rr_ptr   <= next_ptr;
               end else if (accept) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the async FIFO between NUM_REQ requesters in the write-clock domain.
- Grants one requester at a time and lets it stream a burst of up to MAX_BURST beats.
- Never writes while the FIFO reports full, so overflow is prevented rather than flagged.
- Sits between the producer blocks and the FIFO's wr_en/wr_data/full pins.

Parameters:
WIDTH, 8, data width per beat; matches the FIFO WIDTH.
NUM_REQ, 4, number of requesters (2..8).
MAX_BURST, 4, maximum beats per grant (1..16).

Ports:
wr_clk  input  1  write-domain clock; all logic on its rising edge.
rst  input  1  reset, synchronous, active-high.
req  input  NUM_REQ  req[i]=1: requester i has a valid beat on its data slice.
req_data  input  NUM_REQ*WIDTH  beat data; requester i on bits [i*WIDTH +: WIDTH].
ack  output  NUM_REQ  one-hot; ack[i]=1: requester i's beat is written this cycle.
gnt  output  NUM_REQ  registered one-hot grant; all-zero when idle.
fifo_full  input  1  FIFO full flag (write domain).
fifo_wr_en  output  1  FIFO write enable.
fifo_wr_data  output  WIDTH  FIFO write data.
busy  output  1  1 while in state BUSY.

Behaviour:
Reset values:
- During a cycle with rst=1, fifo_wr_en=0 and ack=0 (gated combinationally by ~rst).
- After the reset edge: state=IDLE, gnt=0, busy=0, rr_ptr=0, beat_cnt=0.
- fifo_wr_data=0 whenever gnt=0.
- Reset mid-burst abandons the burst. No beat is written in the reset cycle.

State IDLE:
- If req != 0, pick the first index k with req[k]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- Register gnt = one-hot(k), beat_cnt=0, go to BUSY.
- No write occurs in IDLE. Arbitration latency is 1 cycle from req to gnt.

State BUSY, with g = granted index:
- Combinational accept: accept = req[g] & ~fifo_full & ~rst.
- fifo_wr_en = accept; ack = accept ? gnt : 0.
- fifo_wr_data = req_data slice g; it is driven whenever gnt!=0, even when not accepting.
- On accept: beat_cnt increments.
- Exit to IDLE when req[g]=0 (no beat that cycle), or when accept=1 and beat_cnt==MAX_BURST-1.
- On exit: gnt=0, beat_cnt=0, rr_ptr=(g+1) mod NUM_REQ.
- fifo_full=1 with req[g]=1: stall. Hold gnt and beat_cnt, no write, no timeout; resume when full drops.
- Requester protocol: hold req and data stable until ack. After ack, it may present the next beat in the following cycle or drop req.

Rules:
- Non-granted requesters are never acked.
- A requester dropping req mid-burst loses its grant; the pointer still advances past it.
- Fairness: after requester g's grant ends, g has lowest priority.
- Every cycle: fifo_wr_en implies ~fifo_full. At most one ack bit is set.
- Maximum throughput: MAX_BURST beats per MAX_BURST+1 cycles (one re-arbitration cycle per grant).

Test Plan:
1. Reset, then req=4'b0001 continuously, data 0x10,0x11,... -> gnt=0001 one cycle after req. Writes 0x10..0x13 on 4 consecutive cycles. gnt drops for 1 cycle, then re-grants 0001; 16 beats total in 20 cycles.
2. req=4'b1111 held, each requester always valid -> grants in order 0,1,2,3,0. Each grant writes exactly 4 beats. FIFO receives requester 0's 4 beats, then requester 1's, and so on.
3. Requester 2 streaming, fifo_full forced 1 for 5 cycles mid-burst -> fifo_wr_en=0 and ack=0 for those 5 cycles, gnt stays 0100, beat_cnt holds. The burst resumes and totals 4 beats with no duplicates.
4. Requester 1 granted, drops req after 2 beats, req[3]=1 -> grant ends after 2 beats. The next gnt=1000 (rr_ptr=2, first set index ≥2 is 3).
5. Against a real async_fifo (DEPTH 16), requesters 0 and 3 each push 20 beats with reads stalled -> exactly 16 writes accepted. The FIFO error flag never asserts. After reads resume, all 40 beats arrive in grant order with none lost.
6. rst pulsed for 1 cycle mid-burst with req=1111 -> in the rst cycle fifo_wr_en=0. Next cycle gnt=0, then grant goes to requester 0 (rr_ptr reset to 0).
